// File: rtl/pwm_duty_ramp_if.sv
// Command and status bundle between the register slave and the duty sequencer.
// The master side issues ramp commands. The slave side (the sequencer) returns
// the duty value and the ramp status.
interface pwm_duty_ramp_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_target;
    logic [15:0] cmd_step;
    logic        cmd_abort;
    logic [31:0] duty;
    logic        busy;
    logic        done;
    logic        period_tick;

    modport master (
        output cmd_valid, cmd_target, cmd_step, cmd_abort,
        input  cmd_ready, duty, busy, done, period_tick
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_step, cmd_abort,
        output cmd_ready, duty, busy, done, period_tick
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer for pwm_gen. It accepts a target duty and a step size,
// then walks the duty toward the target by one step per PWM period. Updates
// happen only on the edge that closes a period, so pwm_gen never sees a duty
// change in the middle of a period.
module pwm_duty_ramp #(
    parameter int unsigned PERIOD    = 500000,
    parameter int unsigned DUTY_INIT = 0
) (
    input  logic            clk,
    input  logic            resetn,
    pwm_duty_ramp_if.slave  bus
);

    localparam logic [31:0] LP_LAST      = 32'(PERIOD - 1);
    localparam logic [31:0] LP_DUTY_INIT = 32'(DUTY_INIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pcnt;
    logic [31:0] r_duty;
    logic [31:0] r_tgt;
    logic [31:0] r_stp;
    logic        r_done;

    state_t      w_state_next;
    logic [31:0] w_duty_next;
    logic [31:0] w_tgt_next;
    logic [31:0] w_stp_next;
    logic        w_done_next;
    logic        w_tick;
    logic [31:0] w_diff;

    // Tick marks the last cycle of the period. It is decoded from the counter
    // register, so it cannot glitch from the inputs.
    assign w_tick = (r_pcnt == LP_LAST);

    // Distance to target, taken in whichever direction avoids unsigned wrap.
    assign w_diff = (r_tgt >= r_duty) ? (r_tgt - r_duty) : (r_duty - r_tgt);

    // Free-running period counter that stays aligned with pwm_gen from reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 32'd1;
        end
    end

    // Next-state and datapath decisions for the idle/ramp sequencer.
    // NOTE: every signal gets a default at the top of the block. Without that,
    // any path that skips an assignment would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        w_tgt_next   = r_tgt;
        w_stp_next   = r_stp;
        w_done_next  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Abort is ignored in idle, so a command that arrives together
                // with an abort is still accepted.
                if (bus.cmd_valid) begin
                    w_tgt_next   = (bus.cmd_target > LP_LAST) ? LP_LAST : bus.cmd_target;
                    w_stp_next   = (bus.cmd_step == 16'd0) ? 32'd1 : {16'd0, bus.cmd_step};
                    w_state_next = ST_RAMP;
                end
            end
            ST_RAMP: begin
                // Abort takes priority over a tick on the same edge.
                if (bus.cmd_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (w_diff <= r_stp) begin
                        w_duty_next  = r_tgt;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (r_tgt > r_duty) begin
                        w_duty_next = r_duty + r_stp;
                    end else begin
                        w_duty_next = r_duty - r_stp;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers. Reset clears any captured command immediately.
    // NOTE: target and step are reset as well, even though they are only read
    // in RAMP. A stale command can then never leak past an asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_duty  <= LP_DUTY_INIT;
            r_tgt   <= LP_DUTY_INIT;
            r_stp   <= 32'd1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_duty  <= w_duty_next;
            r_tgt   <= w_tgt_next;
            r_stp   <= w_stp_next;
            r_done  <= w_done_next;
        end
    end

    assign bus.cmd_ready   = (r_state == ST_IDLE);
    assign bus.busy        = (r_state == ST_RAMP);
    assign bus.duty        = r_duty;
    assign bus.done        = r_done;
    assign bus.period_tick = w_tick;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp with PERIOD=10 and DUTY_INIT=5.
// When a command is accepted, the reference model precomputes the full list of
// per-period duty values. It then pops one value on each period boundary.
module tb_pwm_duty_ramp;

    localparam int P     = 10;
    localparam int DINIT = 5;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    pwm_duty_ramp_if bus ();

    pwm_duty_ramp #(.PERIOD(P), .DUTY_INIT(DINIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Its state is the cycle count since reset, the duty, the
    // queue of duty values still to apply, and a done flag.
    int unsigned m_cycles;
    logic [31:0] m_duty;
    logic [31:0] m_q[$];
    bit          m_active;
    bit          m_done;
    bit          m_tick;

    function automatic bit tick_of(input int unsigned cyc);
        return (cyc % P) == (P - 1);
    endfunction

    task automatic plan_ramp(input logic [31:0] start, input logic [31:0] tgt_in,
                             input logic [15:0] st_in);
        longint d;
        longint t;
        longint s;
        d = start;
        t = (tgt_in > P - 1) ? P - 1 : tgt_in;
        s = (st_in == 0) ? 1 : st_in;
        m_q.delete();
        if (d == t) m_q.push_back(32'(t));
        while (d != t) begin
            if (t > d) d = (t - d <= s) ? t : d + s;
            else       d = (d - t <= s) ? t : d - s;
            m_q.push_back(32'(d));
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cycles = 0;
            m_duty   = DINIT;
            m_q.delete();
            m_active = 0;
            m_done   = 0;
        end else begin
            m_tick = tick_of(m_cycles);
            m_done = 0;
            if (!m_active) begin
                if (bus.cmd_valid) begin
                    plan_ramp(m_duty, bus.cmd_target, bus.cmd_step);
                    m_active = 1;
                end
            end else if (bus.cmd_abort) begin
                m_q.delete();
                m_active = 0;
            end else if (m_tick) begin
                m_duty = m_q.pop_front();
                if (m_q.size() == 0) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
            m_cycles++;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        check("duty",        bus.duty,        m_duty);
        check("cmd_ready",   32'(bus.cmd_ready),   32'(!m_active));
        check("busy",        32'(bus.busy),        32'(m_active));
        check("done",        32'(bus.done),        32'(m_done));
        check("period_tick", 32'(bus.period_tick), 32'(resetn && tick_of(m_cycles)));
    end

    task automatic wait_pcnt(input int k);
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge clk);
            #1;
            if ((m_cycles % P) == k) return;
        end
        check("wait_pcnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_period_start();
        wait_pcnt(0);
    endtask

    task automatic issue(input logic [31:0] tgt, input logic [15:0] st);
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = tgt;
        bus.cmd_step   = st;
        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b0;
    endtask

    int n_edges;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = '0;
        bus.cmd_step   = '0;
        bus.cmd_abort  = 1'b0;
        resetn         = 1'b1;
        #2 resetn      = 1'b0;
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;

        // Reset values, and the first tick 9 cycles after release.
        check("rst_duty",  bus.duty, 32'd5);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy",  32'(bus.busy), 32'd0);
        n_edges = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(posedge clk);
            n_edges++;
            #1;
            if (bus.period_tick) break;
        end
        check("first_tick_cycle", 32'(n_edges), 32'd9);

        // Up ramp: target 9, step 2, issued at pcnt 3.
        wait_pcnt(3);
        issue(32'd9, 16'd2);
        check("up_busy",  32'(bus.busy), 32'd1);
        check("up_ready", 32'(bus.cmd_ready), 32'd0);
        wait_period_start();
        check("up_d1", bus.duty, 32'd7);
        wait_period_start();
        check("up_d2", bus.duty, 32'd9);
        check("up_done", 32'(bus.done), 32'd1);
        check("up_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Down ramp issued in the done cycle: 6, 3, 0.
        issue(32'd0, 16'd3);
        wait_period_start();
        check("dn_d1", bus.duty, 32'd6);
        wait_period_start();
        check("dn_d2", bus.duty, 32'd3);
        wait_period_start();
        check("dn_d3", bus.duty, 32'd0);
        check("dn_done", 32'(bus.done), 32'd1);

        // Clamp: target 50, step 0 gives 1..9 over nine ticks.
        issue(32'd50, 16'd0);
        for (int i = 1; i <= 9; i++) begin
            wait_period_start();
            check("clamp_duty", bus.duty, 32'(i));
        end
        check("clamp_done", 32'(bus.done), 32'd1);

        // Valid held through a ramp. The command is re-accepted on the done
        // cycle, and its target equals the duty, so it takes exactly one tick.
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = 32'd7;
        bus.cmd_step   = 16'd1;
        @(posedge clk);
        #1;
        check("hold_ready_busy", 32'(bus.cmd_ready), 32'd0);
        wait_period_start();
        check("hold_d1", bus.duty, 32'd8);
        wait_period_start();
        check("hold_d2", bus.duty, 32'd7);
        check("hold_done", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("hold_reaccepted", 32'(bus.busy), 32'd1);
        wait_period_start();
        check("same_duty", bus.duty, 32'd7);
        check("same_done", 32'(bus.done), 32'd1);

        // Go to 0, then start 0 -> 9 by 2 and abort after the first tick.
        issue(32'd0, 16'd9);
        wait_period_start();
        check("to_zero", bus.duty, 32'd0);
        issue(32'd9, 16'd2);
        wait_period_start();
        check("ab_d1", bus.duty, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        bus.cmd_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_abort = 1'b0;
        check("ab_busy",  32'(bus.busy), 32'd0);
        check("ab_ready", 32'(bus.cmd_ready), 32'd1);
        wait_period_start();
        check("ab_hold", bus.duty, 32'd2);
        check("ab_nodone", 32'(bus.done), 32'd0);

        // Abort on the tick edge: no update.
        issue(32'd9, 16'd2);
        wait_pcnt(9);
        bus.cmd_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_abort = 1'b0;
        check("abt_duty", bus.duty, 32'd2);
        check("abt_done", 32'(bus.done), 32'd0);
        check("abt_busy", 32'(bus.busy), 32'd0);

        // Abort together with a command in idle: the command is accepted.
        bus.cmd_abort = 1'b1;
        issue(32'd4, 16'd2);
        bus.cmd_abort = 1'b0;
        check("abi_busy", 32'(bus.busy), 32'd1);
        wait_period_start();
        check("abi_duty", bus.duty, 32'd4);
        check("abi_done", 32'(bus.done), 32'd1);

        // Reset asserted between edges in the middle of a ramp.
        issue(32'd9, 16'd1);
        wait_period_start();
        wait_period_start();
        check("mr_pre", bus.duty, 32'd6);
        #3 resetn = 1'b0;
        #1;
        check("mr_duty",  bus.duty, 32'd5);
        check("mr_busy",  32'(bus.busy), 32'd0);
        check("mr_ready", 32'(bus.cmd_ready), 32'd1);
        check("mr_tick",  32'(bus.period_tick), 32'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        repeat (3 * P) @(posedge clk);
        #1;
        check("mr_after_duty", bus.duty, 32'd5);
        check("mr_after_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Duty-cycle sequencer for the `pwm_gen` PWM block. It accepts target-duty commands over a valid/ready handshake and drives `pwm_gen`'s `duty` input. The duty value steps toward the target by a programmable amount once per PWM period, and only at the period boundary, so a period never sees a mid-period duty change. It sits between the AXI register slave and `pwm_gen` in the PWM IP and gives servo-friendly slewing instead of jumping straight to the written duty.

## Interface
- `PERIOD`, 500000: PWM period in clk cycles. Must equal `pwm_gen`'s wrap count + 1. Must be ≥ 2.
- `DUTY_INIT`, 0: `duty` value after reset. Must be ≤ `PERIOD`-1.
- `clk` in 1: system clock, all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted (high only in IDLE).
- `cmd_target` in 32: requested final duty, unsigned.
- `cmd_step` in 16: per-period increment magnitude, unsigned.
- `cmd_abort` in 1: stop the ramp and hold the current duty.
- `duty` out 32: registered duty, connects to `pwm_gen.duty`.
- `busy` out 1: ramp in progress (RAMP state).
- `done` out 1: one-cycle pulse when `duty` reaches the target.
- `period_tick` out 1: high during the last cycle of each period.

## Operation
- **Period counter**
  - `pcnt` is 32 bits, free-running 0..`PERIOD`-1, then wraps to 0.
  - It counts from reset regardless of state, so it stays aligned with `pwm_gen`'s counter when both share `resetn`.
  - `period_tick` = (`pcnt` == `PERIOD`-1).
- **Command capture** (on the edge where `cmd_valid` && `cmd_ready`)
  - `tgt` ← min(`cmd_target`, `PERIOD`-1).
  - `stp` ← (`cmd_step` == 0) ? 1 : `cmd_step`, zero-extended to 32 bits.
  - State → RAMP.
- **IDLE**
  - `cmd_ready`=1, `busy`=0, `duty` held.
  - `cmd_abort` is ignored.
  - A command that arrives together with an abort is accepted.
- **RAMP**
  - `cmd_ready`=0, `busy`=1. Nothing happens between ticks.
  - On a tick edge, with diff = |`tgt` − `duty`| computed in 32-bit unsigned without wrap:
    - If diff ≤ `stp`: `duty` ← `tgt`, `done` pulses, state → IDLE.
    - Else if `tgt` > `duty`: `duty` ← `duty` + `stp`.
    - Else: `duty` ← `duty` − `stp`.
  - Because diff > `stp`, `duty` never overshoots and never underflows below 0.
  - A command whose target equals the current duty still enters RAMP. It completes at the next tick with `done` and no change to `duty`.
- **Abort**
  - `cmd_abort` high in RAMP: state → IDLE on that edge, `duty` unchanged, no `done`.
  - Abort and tick on the same edge: abort wins, so no duty update and no `done`.
- **Reset**
  - Values: `duty`=`DUTY_INIT`, `pcnt`=0, state=IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `period_tick`=0.
  - Assertion mid-ramp discards `tgt`/`stp` immediately, with no clock required.

## Timing
- Command latency:
  - Acceptance edge N → `busy`=1 and `cmd_ready`=0 from cycle N+1.
  - The earliest duty change is the first tick edge after N.
- A command accepted on a tick edge does not use that tick. Its first update is one full period later.
- Duty change placement:
  - `duty` updates on the edge that ends the cycle with `pcnt`=`PERIOD`-1.
  - The new value is valid in the cycle where `pcnt`=0, so `pwm_gen` applies it for the whole new period.
- `done` is high for exactly the cycle after the completing tick edge. In that same cycle `cmd_ready`=1 and `busy`=0.
- A new command is accepted no earlier than the cycle `done` is high, which allows back-to-back ramps.
- Ramp length = ceil(|`tgt` − start| / `stp`) ticks, minimum 1.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use `PERIOD`=10 and `DUTY_INIT`=5.
- **Reset:** hold `resetn` low, then release.
  - `duty`=5, `cmd_ready`=1, `busy`=0.
  - `period_tick` is first high in cycle 9 after release, then every 10 cycles.
- **Up ramp:** target 9, step 2, issued at `pcnt`=3.
  - `duty` goes 7 then 9 at the next two period starts.
  - `done` pulses once with `duty`=9, then `cmd_ready`=1.
- **Down ramp and clamp:**
  - From `duty`=9, target 0, step 3: `duty` goes 6, 3, 0, then `done`.
  - Target 50, step 0: clamps to 9 with step 1, giving 1, 2 … 9 over 9 ticks.
- **Handshake:**
  - `cmd_valid` held high during RAMP: not accepted until `done`, and accepted on the `done` cycle.
  - Target equal to the current duty: `done` after exactly one tick, `duty` unchanged.
- **Abort:** from `duty`=0, target 9, step 2.
  - Abort after the first tick: `duty` stays 2, no `done`, `cmd_ready`=1 next cycle.
  - Abort coincident with a tick: no update.
  - Abort in IDLE with `cmd_valid` high: the command is accepted.
- **Reset mid-ramp:** assert `resetn` asynchronously between edges during a ramp.
  - Outputs return to their reset values immediately.
  - After release, `duty` stays 5 with no further updates.
